// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch predictor: table entry layout,
// 2-bit counter encoding and the PC-to-index/tag mapping.
package branch_predictor_pkg;

  // Entry fields are sized for the widest supported PC and truncated by users.
  localparam int BP_ADDR_MAX = 32;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_jump;
    ctr_t                   ctr;
    logic [BP_ADDR_MAX-1:0] tag;
    logic [BP_ADDR_MAX-1:0] target;
  } bp_entry_t;

  function automatic logic [BP_ADDR_MAX-1:0] bp_index(
    input logic [BP_ADDR_MAX-1:0] pc,
    input int                     idx_w,
    input int                     ghr_w,
    input logic [BP_ADDR_MAX-1:0] ghr,
    input logic                   gshare
  );
    logic [BP_ADDR_MAX-1:0] idx;
    idx = (pc >> 2) & ((BP_ADDR_MAX'(1) << idx_w) - BP_ADDR_MAX'(1));
    if (gshare) begin
      idx = idx ^ (ghr & ((BP_ADDR_MAX'(1) << ghr_w) - BP_ADDR_MAX'(1)));
    end
    return idx;
  endfunction

  function automatic logic [BP_ADDR_MAX-1:0] bp_tag(
    input logic [BP_ADDR_MAX-1:0] pc,
    input int                     idx_w
  );
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, EX-side resolve and statistics signals of the predictor.
interface branch_predictor_if #(
  parameter int PC_W = 9
);
  logic [PC_W-1:0] if_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_is_jump;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            ex_pred_taken;
  logic [PC_W-1:0] ex_pred_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;

  logic [15:0]     stat_branches;
  logic [15:0]     stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational 2-bit saturating counter step: up on taken, down otherwise.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic inc_i,
  output ctr_t ctr_o
);

  // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != ST) ctr_o = ctr_t'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_t'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, optional gshare indexing,
// non-speculative global history and saturating resolve statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int GHR_W   = 4,
  parameter int GSHARE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  branch_predictor_if.slave   bp
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t        table_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [15:0]      stat_br_q, stat_br_d;
  logic [15:0]      stat_mp_q, stat_mp_d;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  bp_entry_t        rd_entry, wr_entry, upd_entry;
  logic             rd_hit, wr_hit, upd_we, mispredict;
  ctr_t             ctr_next;

  // Both ports index with the registered history, so an update sees the pre-update GHR.
  assign rd_idx = IDX_W'(bp_index(BP_ADDR_MAX'(bp.if_pc), IDX_W, GHR_W,
                                  BP_ADDR_MAX'(ghr_q), GSHARE != 0));
  assign wr_idx = IDX_W'(bp_index(BP_ADDR_MAX'(bp.ex_pc), IDX_W, GHR_W,
                                  BP_ADDR_MAX'(ghr_q), GSHARE != 0));

  assign rd_entry = table_q[rd_idx];
  assign wr_entry = table_q[wr_idx];
  assign rd_hit   = rd_entry.valid && (rd_entry.tag == bp_tag(BP_ADDR_MAX'(bp.if_pc), IDX_W));
  assign wr_hit   = wr_entry.valid && (wr_entry.tag == bp_tag(BP_ADDR_MAX'(bp.ex_pc), IDX_W));

  assign bp.pred_hit    = rd_hit;
  assign bp.pred_taken  = rd_hit && (rd_entry.is_jump || (rd_entry.ctr inside {WT, ST}));
  assign bp.pred_target = rd_hit ? PC_W'(rd_entry.target) : bp.if_pc + PC_W'(4);

  assign mispredict = bp.ex_valid &&
                      ((bp.ex_taken != bp.ex_pred_taken) ||
                       (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
  assign bp.mispredict       = mispredict;
  assign bp.redirect_pc      = bp.ex_taken ? bp.ex_target : bp.ex_pc + PC_W'(4);
  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;

  sat_counter2 u_sat_counter2 (
    .ctr_i (wr_entry.ctr),
    .inc_i (bp.ex_taken),
    .ctr_o (ctr_next)
  );

  always_comb begin
    upd_we    = 1'b0;
    upd_entry = wr_entry;
    if (bp.ex_valid) begin
      if (wr_hit) begin
        upd_we        = 1'b1;
        upd_entry.ctr = ctr_next;
        if (bp.ex_taken) upd_entry.target = BP_ADDR_MAX'(bp.ex_target);
      end else if (bp.ex_taken) begin
        // Taken miss claims the slot, evicting whatever aliased there.
        upd_we            = 1'b1;
        upd_entry.valid   = 1'b1;
        upd_entry.is_jump = bp.ex_is_jump;
        upd_entry.ctr     = bp.ex_is_jump ? ST : WT;
        upd_entry.tag     = bp_tag(BP_ADDR_MAX'(bp.ex_pc), IDX_W);
        upd_entry.target  = BP_ADDR_MAX'(bp.ex_target);
      end
    end
  end

  always_comb begin
    ghr_d     = ghr_q;
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (bp.ex_valid && !bp.ex_is_jump) ghr_d = {ghr_q[GHR_W-2:0], bp.ex_taken};
    if (bp.ex_valid && (stat_br_q != 16'hFFFF)) stat_br_d = stat_br_q + 16'd1;
    if (mispredict && (stat_mp_q != 16'hFFFF)) stat_mp_d = stat_mp_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
      // NOTE: the table is a flop array, so it can be cleared asynchronously like any register.
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
    end else begin
      ghr_q     <= ghr_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
      if (upd_we) table_q[wr_idx] <= upd_entry;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: a bimodal and a gshare instance driven in lockstep and
// compared against an arithmetic reference model of the predictor rules.
module tb_branch_predictor;

  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int GHR_W   = 4;
  localparam int PC_MOD  = 1 << PC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PC_W-1:0] if_pc, ex_pc, ex_target, ex_pred_target;
  logic            ex_valid, ex_is_jump, ex_taken, ex_pred_taken;

  int n_checks = 0;
  int n_err    = 0;

  branch_predictor_if #(.PC_W(PC_W)) bp0 ();
  branch_predictor_if #(.PC_W(PC_W)) bp1 ();

  assign bp0.if_pc = if_pc;           assign bp1.if_pc = if_pc;
  assign bp0.ex_valid = ex_valid;     assign bp1.ex_valid = ex_valid;
  assign bp0.ex_pc = ex_pc;           assign bp1.ex_pc = ex_pc;
  assign bp0.ex_is_jump = ex_is_jump; assign bp1.ex_is_jump = ex_is_jump;
  assign bp0.ex_taken = ex_taken;     assign bp1.ex_taken = ex_taken;
  assign bp0.ex_target = ex_target;   assign bp1.ex_target = ex_target;
  assign bp0.ex_pred_taken = ex_pred_taken;   assign bp1.ex_pred_taken = ex_pred_taken;
  assign bp0.ex_pred_target = ex_pred_target; assign bp1.ex_pred_target = ex_pred_target;

  branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .GHR_W(GHR_W), .GSHARE(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .bp(bp0)
  );
  branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .GHR_W(GHR_W), .GSHARE(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .bp(bp1)
  );

  // Reference model: instance 0 bimodal, instance 1 gshare.
  bit m_valid [2][ENTRIES];
  bit m_jump  [2][ENTRIES];
  int m_tag   [2][ENTRIES];
  int m_tgt   [2][ENTRIES];
  int m_ctr   [2][ENTRIES];
  int m_ghr   [2];
  int m_br, m_mp;

  function automatic int m_idx(input int g, input int pc);
    int i;
    i = (pc / 4) % ENTRIES;
    if (g == 1) i = i ^ m_ghr[g];
    return i;
  endfunction

  function automatic bit m_mispredict();
    return ex_valid && ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target)));
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_ghr[g] = 0;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[g][i] = 1'b0;
        m_ctr[g][i]   = 0;
      end
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_update();
    int i, t;
    if (!ex_valid) return;
    t = int'(ex_pc) / (ENTRIES * 4);
    for (int g = 0; g < 2; g++) begin
      i = m_idx(g, int'(ex_pc));
      if (m_valid[g][i] && m_tag[g][i] == t) begin
        m_ctr[g][i] = ex_taken ? ((m_ctr[g][i] == 3) ? 3 : m_ctr[g][i] + 1)
                               : ((m_ctr[g][i] == 0) ? 0 : m_ctr[g][i] - 1);
        if (ex_taken) m_tgt[g][i] = int'(ex_target);
      end else if (ex_taken) begin
        m_valid[g][i] = 1'b1;
        m_tag[g][i]   = t;
        m_tgt[g][i]   = int'(ex_target);
        m_jump[g][i]  = ex_is_jump;
        m_ctr[g][i]   = ex_is_jump ? 3 : 2;
      end
      if (!ex_is_jump) m_ghr[g] = (m_ghr[g] * 2 + int'(ex_taken)) % (1 << GHR_W);
    end
    if (m_mispredict() && m_mp < 65535) m_mp++;
    if (m_br < 65535) m_br++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int g, input logic hit, input logic tk,
                           input logic [PC_W-1:0] tgt, input logic mp,
                           input logic [PC_W-1:0] rd, input logic [15:0] sb,
                           input logic [15:0] sm);
    int i, e_tgt, e_rd;
    bit e_hit, e_tk;
    i     = m_idx(g, int'(if_pc));
    e_hit = m_valid[g][i] && (m_tag[g][i] == int'(if_pc) / (ENTRIES * 4));
    e_tk  = e_hit && (m_jump[g][i] || m_ctr[g][i] >= 2);
    e_tgt = e_hit ? m_tgt[g][i] : (int'(if_pc) + 4) % PC_MOD;
    e_rd  = ex_taken ? int'(ex_target) : (int'(ex_pc) + 4) % PC_MOD;
    check($sformatf("d%0d_pred_hit", g), 32'(hit), 32'(e_hit));
    check($sformatf("d%0d_pred_taken", g), 32'(tk), 32'(e_tk));
    check($sformatf("d%0d_pred_target", g), 32'(tgt), e_tgt);
    check($sformatf("d%0d_mispredict", g), 32'(mp), 32'(m_mispredict()));
    check($sformatf("d%0d_redirect_pc", g), 32'(rd), e_rd);
    check($sformatf("d%0d_stat_branches", g), 32'(sb), m_br);
    check($sformatf("d%0d_stat_mispredicts", g), 32'(sm), m_mp);
  endtask

  task automatic sample();
    @(negedge clk);
    check_dut(0, bp0.pred_hit, bp0.pred_taken, bp0.pred_target, bp0.mispredict,
              bp0.redirect_pc, bp0.stat_branches, bp0.stat_mispredicts);
    check_dut(1, bp1.pred_hit, bp1.pred_taken, bp1.pred_target, bp1.mispredict,
              bp1.redirect_pc, bp1.stat_branches, bp1.stat_mispredicts);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [PC_W-1:0] pc, input logic jmp, input logic tk,
                         input logic [PC_W-1:0] tgt, input logic ptk,
                         input logic [PC_W-1:0] ptgt);
    ex_valid = 1'b1; ex_pc = pc; ex_is_jump = jmp; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    if_pc = '0;
    do_reset();

    // Reset state: lookup misses and falls through.
    if_pc = 9'h040;
    sample();
    check("rst_hit", 32'(bp0.pred_hit), 32'd0);
    check("rst_target", 32'(bp0.pred_target), 32'h044);
    advance();

    // Taken branch mispredicted as not-taken allocates, then hits.
    resolve(9'h040, 1'b0, 1'b1, 9'h010, 1'b0, 9'h044);
    sample();
    check("alloc_mispredict", 32'(bp0.mispredict), 32'd1);
    check("alloc_redirect", 32'(bp0.redirect_pc), 32'h010);
    advance();
    idle();
    sample();
    check("alloc_hit", 32'(bp0.pred_hit), 32'd1);
    check("alloc_taken", 32'(bp0.pred_taken), 32'd1);
    check("alloc_target", 32'(bp0.pred_target), 32'h010);
    advance();

    // Two not-taken resolves walk the counter 2 -> 1 -> 0.
    resolve(9'h040, 1'b0, 1'b0, 9'h010, 1'b1, 9'h010);
    sample();
    advance();
    sample();
    check("nt2_mispredict", 32'(bp0.mispredict), 32'd1);
    check("nt2_redirect", 32'(bp0.redirect_pc), 32'h044);
    advance();
    idle();
    sample();
    check("nt_hit", 32'(bp0.pred_hit), 32'd1);
    check("nt_taken", 32'(bp0.pred_taken), 32'd0);
    advance();

    // Aliasing: 0x080 shares index 0 with 0x040 and evicts it.
    resolve(9'h080, 1'b0, 1'b1, 9'h0C0, 1'b0, 9'h084);
    sample();
    advance();
    idle();
    if_pc = 9'h040;
    sample();
    check("alias_old_hit", 32'(bp0.pred_hit), 32'd0);
    advance();
    if_pc = 9'h080;
    sample();
    check("alias_new_hit", 32'(bp0.pred_hit), 32'd1);
    check("alias_new_target", 32'(bp0.pred_target), 32'h0C0);
    advance();

    // Gshare: build history 0b0001, then a jal must not shift it.
    do_reset();
    resolve(9'h000, 1'b0, 1'b1, 9'h020, 1'b0, 9'h004);
    sample();
    advance();
    resolve(9'h040, 1'b1, 1'b1, 9'h100, 1'b0, 9'h044);
    sample();
    advance();
    idle();
    if_pc = 9'h040;
    sample();
    check("gs_idx1_hit", 32'(bp1.pred_hit), 32'd1);
    check("gs_idx1_target", 32'(bp1.pred_target), 32'h100);
    advance();
    if_pc = 9'h004;
    sample();
    check("gs_idx0_hit", 32'(bp1.pred_hit), 32'd1);
    check("gs_idx0_target", 32'(bp1.pred_target), 32'h020);
    check("bim_idx1_hit", 32'(bp0.pred_hit), 32'd0);
    advance();

    // Randomised traffic over a small PC pool so hits, aliasing and wrap occur.
    for (int n = 0; n < 300; n++) begin
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_pc      = ($urandom_range(0, 7) == 0) ? PC_W'(4 * $urandom_range(0, 127))
                                               : PC_W'(4 * $urandom_range(0, 47));
      ex_is_jump = ($urandom_range(0, 3) == 0);
      ex_taken   = ex_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
      ex_target  = PC_W'(4 * $urandom_range(0, 127));
      ex_pred_taken  = 1'($urandom_range(0, 1));
      ex_pred_target = ($urandom_range(0, 1) != 0) ? ex_target
                                                   : PC_W'(4 * $urandom_range(0, 127));
      if_pc = ($urandom_range(0, 2) == 0) ? ex_pc : PC_W'(4 * $urandom_range(0, 47));
      sample();
      advance();
    end

    // Saturate both statistics with a long run of mispredicting resolves.
    resolve(9'h040, 1'b0, 1'b1, 9'h010, 1'b0, 9'h044);
    repeat (32'h10005) begin
      @(negedge clk);
      model_update();
      @(posedge clk);
      #1;
    end
    if_pc = 9'h040;
    sample();
    check("sat_mispredicts", 32'(bp0.stat_mispredicts), 32'hFFFF);
    check("sat_branches", 32'(bp0.stat_branches), 32'hFFFF);
    check("sat_hit_before_reset", 32'(bp0.pred_hit), 32'd1);

    // Asynchronous reset between edges clears state without waiting for clk.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_dut(0, bp0.pred_hit, bp0.pred_taken, bp0.pred_target, bp0.mispredict,
              bp0.redirect_pc, bp0.stat_branches, bp0.stat_mispredicts);
    check_dut(1, bp1.pred_hit, bp1.pred_taken, bp1.pred_target, bp1.mispredict,
              bp1.redirect_pc, bp1.stat_branches, bp1.stat_mispredicts);
    check("arst_hit", 32'(bp0.pred_hit), 32'd0);
    check("arst_mispredicts", 32'(bp0.stat_mispredicts), 32'd0);
    check("arst_mispredict_comb", 32'(bp0.mispredict), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameters: PC_W, default 9, PC width; ENTRIES, default 16, table entries (power of 2, >=4); GHR_W, default 4, global history bits (<= log2 ENTRIES); GSHARE, default 0, 0=bimodal index, 1=index XOR history.
REQ-002 The block SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have ports: if_pc  in  PC_W  fetch PC; pred_hit  out  1  tag match; pred_taken  out  1  predict taken; pred_target  out  PC_W  predicted target.
REQ-004 The block SHALL have ports: ex_valid  in  1  EX-stage control-transfer resolves; ex_pc  in  PC_W; ex_is_jump  in  1  jal/jalr; ex_taken  in  1  actual outcome; ex_target  in  PC_W  actual target.
REQ-005 The block SHALL have ports: ex_pred_taken  in  1; ex_pred_target  in  PC_W (both as predicted at fetch); mispredict  out  1  flush request; redirect_pc  out  PC_W  correct next PC.
REQ-006 The block SHALL have ports: stat_branches  out  16  resolved count; stat_mispredicts  out  16  mispredict count.

Function
REQ-007 The block SHALL use IDX_W=log2(ENTRIES) and index = if_pc[IDX_W+1:2], with XOR of the GHR into the low GHR_W bits when GSHARE=1.
REQ-008 The block SHALL use tag = pc[PC_W-1:IDX_W+2]; each entry SHALL hold valid, tag, target, is_jump and a 2-bit saturating counter.
REQ-009 Prediction SHALL be combinational from registered state: pred_hit = valid && tag match; pred_taken = pred_hit && (is_jump || counter[1]); pred_target = entry target; on a miss, pred_taken=0 and pred_target=if_pc+4.
REQ-010 mispredict SHALL be combinational: ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
REQ-011 redirect_pc SHALL be ex_target when ex_taken, else ex_pc+4, with PC_W-bit wrap.
REQ-012 The update SHALL occur on the clk edge when ex_valid=1, using ex_pc indexed with the GHR value before this update.
REQ-013 On a hit, the update SHALL increment the counter on taken (saturate at 3) and decrement it on not-taken (saturate at 0), and write target=ex_target when ex_taken.
REQ-014 On a miss with ex_taken=1, the update SHALL allocate (overwrite) the entry: valid=1, tag, target, is_jump=ex_is_jump, counter=2 (3 if jump).
REQ-015 On a miss with ex_taken=0, the update SHALL leave the table unchanged.
REQ-016 The GHR SHALL update only on ex_valid && !ex_is_jump as {GHR[GHR_W-2:0], ex_taken}; it is non-speculative.
REQ-017 Same-cycle read/write to one entry SHALL return the old value to the fetch side (no bypass).
REQ-018 stat_branches SHALL increment on each ex_valid; stat_mispredicts SHALL increment on each mispredict; both SHALL saturate at 0xFFFF, not wrap.

Reset
REQ-019 Assertion of reset SHALL immediately clear all valid bits, counters, GHR and both stats to 0, including mid-update; outputs then show a miss with mispredict driven by inputs only.
REQ-020 Target, tag and is_jump storage need not be reset.

Structure
REQ-021 The shared package SHALL hold the entry struct (bp_entry_t), the counter constants (SNT=0, WNT=1, WT=2, ST=3) and the index/tag helper function.
REQ-022 The design SHALL use one sub-module, sat_counter2, a combinational 2-bit saturating update; the table SHALL be a flop array, not a memory macro.

Verification
REQ-023 Reset, then if_pc=0x040 -> pred_hit=0, pred_taken=0, pred_target=0x044, stats=0.
REQ-024 EX taken branch ex_pc=0x040, ex_target=0x010, mispredicted -> mispredict=1, redirect_pc=0x010; next cycle if_pc=0x040 -> hit, taken, target 0x010.
REQ-025 Same entry resolved not-taken twice -> counter 2->1->0; pred_taken=0; the second resolve with ex_pred_taken=1 raises mispredict, redirect_pc=0x044.
REQ-026 Aliasing: allocate 0x040 then taken branch at 0x080 (same index 0, tag 2) -> 0x040 then misses, 0x080 hits.
REQ-027 GSHARE=1: history 0b0001 -> if_pc=0x040 reads index 1; jal resolves leave GHR unchanged.
REQ-028 Drive 0x10005 mispredicting resolves -> stat_mispredicts holds 0xFFFF; reset asserted mid-cycle -> all stats 0 and no hit asynchronously.
